// File: rtl/led_pkg.sv
// Shared types and constants for the LED output stage and the pattern generator.
// Contents: default timing constants, duty_t, fade_state_e, max_duty().
package led_pkg;

  localparam int unsigned DEFAULT_NUM_LEDS          = 6;
  localparam int unsigned DEFAULT_PWM_BITS          = 8;
  localparam int unsigned DEFAULT_PRESCALE          = 4;
  localparam int unsigned DEFAULT_FADE_STEP         = 1;
  localparam int unsigned DEFAULT_FADE_STEP_PERIODS = 64;
  localparam int unsigned DEFAULT_WAIT_CYCLES       = 27_000_000 / 4;

  typedef logic [DEFAULT_PWM_BITS-1:0] duty_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_e;

  // Full-on duty for a given PWM width.
  function automatic int unsigned max_duty(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: target/duty registers, saturating ramp, optional gamma map,
// PWM compare to an active-low LED bit.
// Build option: LED_FADER_GAMMA_EN selects a squared (perceptual) duty curve.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load, on     load new target (on ? full : zero)
//   ramp         step duty one FADE_STEP toward target
//   pwm_cnt      shared PWM counter
//   led          registered LED pin, active-low
//   done_c       duty equals target
//   differs_c    requested target differs from current duty
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int unsigned FADE_STEP = DEFAULT_FADE_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                on,
  input  logic                ramp,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                done_c,
  output logic                differs_c
);

  localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(max_duty(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] diff;
  logic [PWM_BITS-1:0] step;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] duty_eff;
  logic                lit;

  // Saturating move toward target, never overshooting.
  always_comb begin
    diff      = (target > duty) ? (target - duty) : (duty - target);
    step      = (diff < STEP) ? diff : STEP;
    duty_next = (target > duty) ? (duty + step) : (duty - step);
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  always_comb begin
    sq       = (2*PWM_BITS)'(duty) * (2*PWM_BITS)'(duty);
    duty_eff = (duty == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign duty_eff = duty;
`endif

  // Full duty is solid on; otherwise lit while the counter is below duty.
  assign lit       = (duty_eff == MAX) || (pwm_cnt < duty_eff);
  assign done_c    = (duty == target);
  assign differs_c = ((on ? MAX : '0) != duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      duty   <= '0;
      led    <= 1'b1;
    end else begin
      if (load) target <= on ? MAX : '0;
      if (ramp) duty   <= duty_next;
      led <= ~lit;
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// LED output stage: accepts on/off patterns and fades each active-low LED
// to its new brightness with PWM.
// Build option: LED_FADER_GAMMA_EN (passed through to the channels).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pattern        requested on/off pattern, bit i -> LED i
//   pattern_valid  pattern offered
//   pattern_ready  pattern accepted on valid & ready
//   busy           fade in progress
//   led            LED pins, active-low
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = DEFAULT_NUM_LEDS,
  parameter int unsigned PWM_BITS          = DEFAULT_PWM_BITS,
  parameter int unsigned PRESCALE          = DEFAULT_PRESCALE,
  parameter int unsigned FADE_STEP         = DEFAULT_FADE_STEP,
  parameter int unsigned FADE_STEP_PERIODS = DEFAULT_FADE_STEP_PERIODS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic                pattern_valid,
  output logic                pattern_ready,
  output logic                busy,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SC_W = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SC_W-1:0]     step_cnt;
  logic                tick;
  logic                period_end;
  logic                ramp;
  logic                xfer;
  logic [NUM_LEDS-1:0] done_c;
  logic [NUM_LEDS-1:0] differs_c;
  fade_state_e         state;
  fade_state_e         state_next;

  assign tick       = (prescaler == PS_W'(PRESCALE - 1));
  assign period_end = tick && (pwm_cnt == PWM_BITS'(max_duty(PWM_BITS)));
  assign ramp       = period_end && (step_cnt == SC_W'(FADE_STEP_PERIODS - 1));
  assign xfer       = pattern_valid && pattern_ready;

  // Free-running timebase: prescaler -> PWM counter -> ramp-step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      step_cnt  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (period_end) step_cnt <= ramp ? '0 : step_cnt + SC_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (xfer),
      .on        (pattern[i]),
      .ramp      (ramp),
      .pwm_cnt   (pwm_cnt),
      .led       (led[i]),
      .done_c    (done_c[i]),
      .differs_c (differs_c[i])
    );
  end

  // State register; ready/busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pattern_ready <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      pattern_ready <= (state_next == IDLE);
      busy          <= (state_next == FADING);
    end
  end

  // Done check sees registered duty, so a final ramp step is seen one cycle later.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer && (|differs_c)) state_next = FADING;
      FADING:  if (&done_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
